// File: rtl/array_min_reduce.sv
// array_min_reduce: pipelined unsigned minimum over a packed array.
// A balanced binary compare tree is split into LAT register stages. The
// input array travels beside the tree so that out_arr and out_min always
// belong to the same array. All stages share one advance enable, so the
// pipeline either moves forward as a whole or holds as a whole.
// Optional feature: define ARRAY_MIN_IDX_EN to add out_idx. A 6-bit index
// then travels with every tree node.

// One tree node: 2-input unsigned min. On a tie the a side (lower index) wins.
module array_min_node #(
    parameter int dataW = 8
) (
    input  logic [dataW-1:0] a_val,
    input  logic [dataW-1:0] b_val,
`ifdef ARRAY_MIN_IDX_EN
    input  logic [5:0]       a_idx,
    input  logic [5:0]       b_idx,
    output logic [5:0]       y_idx,
`endif
    output logic [dataW-1:0] y_val
);
    // b replaces a only when it is strictly smaller, so ties keep the lower index
    logic take_b;
    assign take_b = (b_val < a_val);
    assign y_val  = take_b ? b_val : a_val;
`ifdef ARRAY_MIN_IDX_EN
    assign y_idx  = take_b ? b_idx : a_idx;
`endif
endmodule

module array_min_reduce #(
    parameter int dataW = 8,
    parameter int ArrL  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [dataW*ArrL-1:0]  in_arr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [dataW*ArrL-1:0]  out_arr,
    output logic [dataW-1:0]       out_min
`ifdef ARRAY_MIN_IDX_EN
    ,output logic [5:0]            out_idx
`endif
);
    // Returns the number of nodes at tree level k. Level 0 holds the raw elements.
    function automatic int nodes(input int k);
        return (ArrL + (1 << k) - 1) >> k;
    endfunction

    // Returns the flat offset of level k (k >= 1) in the stage node arrays.
    function automatic int base(input int k);
        int s;
        s = 0;
        for (int i = 1; i < k; i++) s += nodes(i);
        return s;
    endfunction

    localparam int LAT = (ArrL > 2) ? $clog2(ArrL) : 1;
    localparam int TOT = base(LAT + 1);

    logic                  adv;
    logic [LAT:1]          vld_q, vld_d;
    logic [dataW*ArrL-1:0] arr_q [1:LAT];
    logic [dataW*ArrL-1:0] arr_d [1:LAT];
    logic [dataW-1:0]      nxt_val [TOT];
    logic [dataW-1:0]      val_q   [TOT];
    logic [dataW-1:0]      val_d   [TOT];
`ifdef ARRAY_MIN_IDX_EN
    logic [5:0]            nxt_idx [TOT];
    logic [5:0]            idx_q   [TOT];
    logic [5:0]            idx_d   [TOT];
`endif

    assign out_valid = vld_q[LAT];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_arr   = arr_q[LAT];
    assign out_min   = val_q[TOT-1];
`ifdef ARRAY_MIN_IDX_EN
    assign out_idx   = idx_q[TOT-1];
`endif

    // Tree levels: level k pairs up the nodes of level k-1. An odd node passes through.
    for (genvar k = 1; k <= LAT; k++) begin : g_stg
        localparam int NP = nodes(k - 1);
        localparam int NK = nodes(k);
        localparam int OB = base(k);
        for (genvar j = 0; j < NK; j++) begin : g_node
            logic [dataW-1:0] a_val;
`ifdef ARRAY_MIN_IDX_EN
            logic [5:0]       a_idx;
`endif
            if (k == 1) begin : g_src_in
                assign a_val = in_arr[(2*j)*dataW +: dataW];
`ifdef ARRAY_MIN_IDX_EN
                assign a_idx = 6'(2*j);
`endif
            end else begin : g_src_reg
                assign a_val = val_q[base(k-1) + 2*j];
`ifdef ARRAY_MIN_IDX_EN
                assign a_idx = idx_q[base(k-1) + 2*j];
`endif
            end

            if (2*j + 1 < NP) begin : g_cmp
                logic [dataW-1:0] b_val;
`ifdef ARRAY_MIN_IDX_EN
                logic [5:0]       b_idx;
`endif
                if (k == 1) begin : g_b_in
                    assign b_val = in_arr[(2*j+1)*dataW +: dataW];
`ifdef ARRAY_MIN_IDX_EN
                    assign b_idx = 6'(2*j+1);
`endif
                end else begin : g_b_reg
                    assign b_val = val_q[base(k-1) + 2*j + 1];
`ifdef ARRAY_MIN_IDX_EN
                    assign b_idx = idx_q[base(k-1) + 2*j + 1];
`endif
                end
                array_min_node #(.dataW(dataW)) u_node (
                    .a_val (a_val),
                    .b_val (b_val),
`ifdef ARRAY_MIN_IDX_EN
                    .a_idx (a_idx),
                    .b_idx (b_idx),
                    .y_idx (nxt_idx[OB+j]),
`endif
                    .y_val (nxt_val[OB+j])
                );
            end else begin : g_pass
                assign nxt_val[OB+j] = a_val;
`ifdef ARRAY_MIN_IDX_EN
                assign nxt_idx[OB+j] = a_idx;
`endif
            end
        end
    end

    // Next state: hold everything unless the pipeline advances as a whole
    always_comb begin
        vld_d = vld_q;
        arr_d = arr_q;
        val_d = val_q;
`ifdef ARRAY_MIN_IDX_EN
        idx_d = idx_q;
`endif
        if (adv) begin
            vld_d[1] = in_valid;
            arr_d[1] = in_arr;
            for (int k = 2; k <= LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                arr_d[k] = arr_q[k-1];
            end
            val_d = nxt_val;
`ifdef ARRAY_MIN_IDX_EN
            idx_d = nxt_idx;
`endif
        end
    end

    // Stage registers. An async reset drops every in-flight array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 1; k <= LAT; k++) arr_q[k] <= '0;
            for (int n = 0; n < TOT; n++) begin
                val_q[n] <= '0;
`ifdef ARRAY_MIN_IDX_EN
                idx_q[n] <= '0;
`endif
            end
        end else begin
            vld_q <= vld_d;
            arr_q <= arr_d;
            val_q <= val_d;
`ifdef ARRAY_MIN_IDX_EN
            idx_q <= idx_d;
`endif
        end
    end
endmodule

// File: tb/tb_array_min_reduce.sv
// Testbench for array_min_reduce (dataW=8, ArrL=4, LAT=2).
// Directed vectors come from a table. Hand sequences cover back-to-back
// transfer, stall and mid-flight reset. A random phase follows. A scoreboard
// queue holds each accepted array, and a plain linear scan gives its
// expected minimum and index.
module tb_array_min_reduce;
    localparam int DW  = 8;
    localparam int AL  = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW*AL-1:0] in_arr = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW*AL-1:0] out_arr;
    logic [DW-1:0]   out_min;
`ifdef ARRAY_MIN_IDX_EN
    logic [5:0]      out_idx;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] expq[$];

    array_min_reduce #(.dataW(DW), .ArrL(AL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_arr    (in_arr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_arr   (out_arr),
`ifdef ARRAY_MIN_IDX_EN
        .out_idx   (out_idx),
`endif
        .out_min   (out_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // Linear scan. A strict less-than keeps the first (lowest-index) minimum.
    function automatic logic [13:0] ref_min(input logic [31:0] a);
        logic [7:0] m;
        logic [5:0] ix;
        m  = a[7:0];
        ix = 6'd0;
        for (int i = 1; i < AL; i++) begin
            if (a[i*8 +: 8] < m) begin
                m  = a[i*8 +: 8];
                ix = 6'(i);
            end
        end
        return {ix, m};
    endfunction

    // Monitor samples at the falling edge, when inputs and outputs are settled
    logic        prev_stall = 1'b0;
    logic [31:0] prev_arr;
    logic [7:0]  prev_min;
    logic [31:0] sb_e;
    logic [13:0] sb_r;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_eq_adv", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_arr", out_arr, prev_arr);
                chk("hold_min", out_min, prev_min);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: output arr %0h with no pending input", out_arr);
                end else begin
                    sb_e = expq.pop_front();
                    sb_r = ref_min(sb_e);
                    chk("sb_arr", out_arr, sb_e);
                    chk("sb_min", out_min, sb_r[7:0]);
`ifdef ARRAY_MIN_IDX_EN
                    chk("sb_idx", out_idx, sb_r[13:8]);
`endif
                end
            end
            if (in_valid && in_ready) expq.push_back(in_arr);
            prev_stall = out_valid && !out_ready;
            prev_arr   = out_arr;
            prev_min   = out_min;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Send one array into an idle pipeline, then check the latency and the result
    task automatic run_vec(input string nm, input logic [31:0] a,
                           input logic [7:0] emin, input logic [5:0] eidx);
        int lat;
        in_valid = 1'b1;
        in_arr   = a;
        step();
        in_valid = 1'b0;
        in_arr   = '0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({nm, "_lat"}, lat + 1, LAT);
        chk({nm, "_min"}, out_min, emin);
        chk({nm, "_arr"}, out_arr, a);
`ifdef ARRAY_MIN_IDX_EN
        chk({nm, "_idx"}, out_idx, eidx);
`else
        if (eidx > 6'd63) $display("unreachable");
`endif
        step();
    endtask

    typedef struct {
        logic [31:0] arr;
        logic [7:0]  emin;
        logic [5:0]  eidx;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [31:0] a, b, c;
        vecs[0] = '{pk(9, 3, 7, 5),         8'd3,   6'd1};
        vecs[1] = '{pk(4, 2, 2, 200),       8'd2,   6'd1};
        vecs[2] = '{pk(255, 255, 255, 255), 8'd255, 6'd0};
        vecs[3] = '{pk(0, 0, 0, 1),         8'd0,   6'd0};
        vecs[4] = '{pk(10, 20, 30, 1),      8'd1,   6'd3};
        vecs[5] = '{pk(7, 7, 7, 6),         8'd6,   6'd3};
        vecs[6] = '{pk(3, 9, 2, 2),         8'd2,   6'd2};

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_min", out_min, 8'd0);
        chk("rst_out_arr", out_arr, 32'd0);
`ifdef ARRAY_MIN_IDX_EN
        chk("rst_out_idx", out_idx, 6'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].arr, vecs[i].emin, vecs[i].eidx);

        // back-to-back: consecutive outputs with no bubble between them
        a = pk(1, 2, 3, 4);
        b = pk(8, 6, 0, 5);
        in_valid = 1'b1; in_arr = a; step();
        in_arr = b; step();
        in_valid = 1'b0;
        chk("b2b_a_valid", out_valid, 1'b1);
        chk("b2b_a_min", out_min, 8'd1);
`ifdef ARRAY_MIN_IDX_EN
        chk("b2b_a_idx", out_idx, 6'd0);
`endif
        step();
        chk("b2b_b_valid", out_valid, 1'b1);
        chk("b2b_b_min", out_min, 8'd0);
`ifdef ARRAY_MIN_IDX_EN
        chk("b2b_b_idx", out_idx, 6'd2);
`endif
        step();
        chk("b2b_empty", out_valid, 1'b0);

        // stall: A parked at the output for 3 cycles, C queued behind it
        a = pk(9, 3, 7, 5);
        c = pk(40, 50, 60, 20);
        out_ready = 1'b0;
        in_valid = 1'b1; in_arr = a; step();
        in_arr = c; step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_min", out_min, 8'd3);
            chk("stall_arr", out_arr, a);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", in_ready, 1'b1);
        step();
        chk("stall_next_valid", out_valid, 1'b1);
        chk("stall_next_min", out_min, 8'd20);
        chk("stall_next_arr", out_arr, c);
        step();
        chk("stall_drained", out_valid, 1'b0);

        // reset with two arrays in flight
        in_valid = 1'b1; in_arr = pk(5, 6, 7, 8); step();
        in_arr = pk(11, 12, 13, 14); step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("postrst_no_stale", out_valid, 1'b0);
            step();
        end
        run_vec("postrst", pk(0, 0, 0, 1), 8'd0, 6'd0);

        // random traffic with random backpressure, checked by the scoreboard
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            for (int i = 0; i < AL; i++)
                r[i*8 +: 8] = ($urandom % 2 == 0) ? 8'($urandom_range(0, 3))
                                                  : 8'($urandom_range(0, 255));
            in_valid  = ($urandom % 4) != 0;
            in_arr    = r;
            out_ready = ($urandom % 3) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < LAT + 3; i++) step();
        chk("drain_empty", expq.size(), 0);
        chk("drain_idle", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
